drp_xadc_responder: RTL and testbench
=====================================

DRP_XADC_RESPONDER -- requirements
Module: drp_xadc_responder

Interface
REQ-001 SHALL have parameter DRP_LATENCY, default 4, cycles from accepted DEN to DRDY (legal 1..15).
REQ-002 SHALL have parameter CONV_CYCLES, default 26, cycles per emulated channel conversion (legal 2..255).
REQ-003 SHALL have port S_AXI_ACLK, input, 1 bit: the single clock.
REQ-004 SHALL have port S_AXI_ARESETN, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port DADDR, input, 7 bits: DRP register address.
REQ-006 SHALL have port DEN, input, 1 bit: DRP access strobe.
REQ-007 SHALL have port DWE, input, 1 bit: write enable, qualified by DEN.
REQ-008 SHALL have port DI, input, 16 bits: DRP write data.
REQ-009 SHALL have port sample_data, input, 48 bits: four 12-bit aux samples, with channel n at [12n+11:12n].
REQ-010 SHALL have port DO, output, 16 bits: DRP read data.
REQ-011 SHALL have port DRDY, output, 1 bit: access-complete pulse.
REQ-012 SHALL have port BUSY, output, 1 bit: conversion in progress.
REQ-013 SHALL have port EOS, output, 1 bit: end-of-sequence pulse.
REQ-014 SHALL have port drp_err, output, 1 bit: sticky protocol error flag.
REQ-015 SHALL have port alarm, output, 1 bit: VAUX0 over-threshold indication.

Function
REQ-016 SHALL map addresses as follows; every other address SHALL read 0x0000 and ignore writes.
- 0x10..0x13: VAUX0..3 results, read-only, value {sample[11:0],4'h0}.
- 0x41, 0x42, 0x49: read/write configuration registers.
- 0x50: VAUX0 upper alarm threshold.
REQ-017 SHALL accept DEN only when no access is pending; the read value or write data SHALL be captured in the DEN cycle.
REQ-018 SHALL pulse DRDY for exactly 1 cycle, DRP_LATENCY cycles after the accepted DEN.
REQ-019 SHALL commit writes in the DRDY cycle.
REQ-020 SHALL drive DO valid in the DRDY cycle, hold DO until the next DRDY, and drive DO = DI after a write.
REQ-021 SHALL ignore DEN asserted while an access is pending (no second DRDY) and set drp_err, which stays set until reset.
REQ-022 SHALL silently drop DRP writes to 0x10..0x13, with DRDY still pulsed.
REQ-023 SHALL run the sequencer FSM IDLE -> CONV -> (NEXT -> CONV)* -> EOS -> IDLE.
REQ-024 SHALL leave IDLE only when reg 0x41[15:12] == 4'h2 (continuous mode) and the latched channel mask is non-zero.
REQ-025 SHALL latch the mask from reg 0x49[3:0] on IDLE exit; mask writes mid-sequence SHALL take effect at the next sequence.
REQ-026 SHALL convert enabled channels in ascending order.
REQ-027 SHALL hold BUSY high for exactly CONV_CYCLES cycles per channel.
REQ-028 SHALL, on the last BUSY cycle, load the channel's result register from sample_data sampled that cycle.
REQ-029 SHALL drop BUSY for 1 cycle between channels (NEXT state).
REQ-030 SHALL, after the last enabled channel, pulse EOS for 1 cycle; if still in continuous mode the next sequence SHALL start the following cycle.
REQ-031 SHALL finish the current sequence when the mode leaves continuous mid-sequence, then stay in IDLE.
REQ-032 SHALL, when a DRP read and a result update of the same register coincide, return the pre-update value.

Reset
REQ-033 SHALL, while S_AXI_ARESETN is low at a clock edge, set DO=0, DRDY=0, BUSY=0, EOS=0, drp_err=0 and alarm=0.
REQ-034 SHALL, under the same reset, set results to 0, 0x41=0x2000, 0x42=0x0400, 0x49=0x000F and 0x50=0xFFFF.
REQ-035 SHALL, on reset mid-access or mid-conversion, abort the access or conversion with no DRDY/EOS and return the FSM to IDLE.

Configuration
REQ-036 SHALL, with DRP_RESP_ALARM_EN defined, register alarm = 1 when a VAUX0 result update exceeds reg 0x50 (unsigned 16-bit compare), and clear it on a VAUX0 update that does not exceed.
REQ-037 SHALL, without DRP_RESP_ALARM_EN, tie alarm to 0 and treat 0x50 as unmapped (reads 0, writes ignored).

Structure
REQ-038 SHALL place register address constants, config reset values and the FSM state enum in shared package drp_resp_pkg.
REQ-039 SHALL implement the sequencer FSM as sub-module drp_resp_sequencer; the DRP decode and register file SHALL remain in the top module.

Verification
REQ-040 SHALL cover reset read-back: read 0x41, 0x42, 0x49 -> DO=0x2000, 0x0400, 0x000F, each with DRDY 4 cycles after DEN.
REQ-041 SHALL cover conversion: sample_data ch2=0xABC, mask 0x000F -> BUSY 4x26 cycles with 1-cycle gaps, EOS once, then read 0x12 -> 0xABC0.
REQ-042 SHALL cover a mid-sequence mask write: write 0x49=0x0001 during ch1 -> current sequence completes ch2/ch3, next sequence converts ch0 only.
REQ-043 SHALL cover protocol error: second DEN 2 cycles after the first -> one DRDY only, drp_err=1 until reset.
REQ-044 SHALL cover a read-only write: write 0x11=0x1234 -> DRDY pulses, later read of 0x11 returns the last conversion result.
REQ-045 SHALL cover alarm under DRP_RESP_ALARM_EN: 0x50=0x8000, ch0 sample=0x900 -> alarm=1 after the update; ch0 sample=0x100 -> alarm=0.

Source files
------------

// File: rtl/drp_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : drp_resp_pkg
// Description : Shared constants and types for the DRP/XADC responder:
//               register addresses, configuration reset values, sequencer
//               state encoding and a channel-search helper.
// Revision    : 1.0 - initial release
// ============================================================================
package drp_resp_pkg;

  // DRP register map
  localparam logic [6:0] C_ADDR_VAUX0 = 7'h10;  // 0x10..0x13 are VAUX0..3
  localparam logic [6:0] C_ADDR_CFG0  = 7'h41;
  localparam logic [6:0] C_ADDR_CFG1  = 7'h42;
  localparam logic [6:0] C_ADDR_SEQ   = 7'h49;
  localparam logic [6:0] C_ADDR_ALM   = 7'h50;

  // Configuration reset values
  localparam logic [15:0] C_CFG0_RST = 16'h2000;
  localparam logic [15:0] C_CFG1_RST = 16'h0400;
  localparam logic [15:0] C_SEQ_RST  = 16'h000F;
  localparam logic [15:0] C_ALM_RST  = 16'hFFFF;

  // CFG0[15:12] value selecting continuous sequencing
  localparam logic [3:0] C_MODE_CONT = 4'h2;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_CONV = 2'd1,
    SEQ_NEXT = 2'd2,
    SEQ_EOS  = 2'd3
  } seq_state_e;

  // Lowest enabled channel at or above 'from'; bit 2 set means none left.
  function automatic logic [2:0] next_channel(input logic [3:0] mask,
                                              input logic [2:0] from);
    logic [2:0] r;
    r = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if ((i >= int'(from)) && mask[2'(i)]) r = 3'(i);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/drp_resp_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : drp_resp_sequencer
// Description : Emulated XADC channel sequencer. Walks the enabled channels
//               of a mask latched at sequence start in ascending order, holds
//               busy for CONV_CYCLES per channel with a one-cycle gap between
//               channels, and pulses eos after the last channel.
// Ports       : clk_i, rst_ni     - clock, synchronous active-low reset
//               cont_mode_i       - continuous mode selected
//               mask_i[3:0]       - live channel enable mask
//               busy_o, eos_o     - conversion busy / end-of-sequence pulse
//               load_o, load_ch_o - result capture strobe and channel
// Revision    : 1.0 - initial release
// ============================================================================
module drp_resp_sequencer
  import drp_resp_pkg::*;
#(
  parameter int CONV_CYCLES = 26
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cont_mode_i,
  input  logic [3:0] mask_i,
  output logic       busy_o,
  output logic       eos_o,
  output logic       load_o,
  output logic [1:0] load_ch_o
);

  localparam logic [7:0] C_LAST = 8'(CONV_CYCLES - 1);

  seq_state_e state_q, state_d;
  logic [3:0] mask_q, mask_d;
  logic [1:0] ch_q, ch_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] first_ch, after_ch;

  assign first_ch = next_channel(mask_i, 3'd0);
  assign after_ch = next_channel(mask_q, {1'b0, ch_q} + 3'd1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= SEQ_IDLE;
      mask_q  <= 4'h0;
      ch_q    <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    busy_o    = 1'b0;
    eos_o     = 1'b0;
    load_o    = 1'b0;
    load_ch_o = ch_q;
    case (state_q)
      // EOS behaves like IDLE for the start decision so back-to-back
      // sequences begin on the cycle right after the EOS pulse.
      SEQ_IDLE, SEQ_EOS: begin
        eos_o   = (state_q == SEQ_EOS);
        state_d = SEQ_IDLE;
        if (cont_mode_i && (mask_i != 4'h0)) begin
          state_d = SEQ_CONV;
          mask_d  = mask_i;
          ch_d    = first_ch[1:0];
          cnt_d   = 8'd0;
        end
      end
      SEQ_CONV: begin
        busy_o = 1'b1;
        if (cnt_q == C_LAST) begin
          load_o = 1'b1;
          cnt_d  = 8'd0;
          if (after_ch[2]) begin
            state_d = SEQ_EOS;
          end else begin
            state_d = SEQ_NEXT;
            ch_d    = after_ch[1:0];
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      SEQ_NEXT: state_d = SEQ_CONV;
      default:  state_d = SEQ_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/drp_xadc_responder.sv
`default_nettype none
// ============================================================================
// Module      : drp_xadc_responder
// Description : DRP slave emulating a small XADC register set. Decodes DRP
//               accesses with a fixed DRDY latency, holds configuration and
//               result registers, and drives the channel sequencer.
// Ports       : S_AXI_ACLK, S_AXI_ARESETN - clock, sync active-low reset
//               DADDR, DEN, DWE, DI        - DRP request
//               DO, DRDY                   - DRP response
//               sample_data[47:0]          - four 12-bit aux samples
//               BUSY, EOS                  - sequencer status
//               drp_err                    - sticky overlapping-DEN flag
//               alarm                      - VAUX0 over-threshold
// Build macro : DRP_RESP_ALARM_EN - enables threshold reg 0x50 and alarm
// Revision    : 1.0 - initial release
// ============================================================================
module drp_xadc_responder
  import drp_resp_pkg::*;
#(
  parameter int DRP_LATENCY = 4,
  parameter int CONV_CYCLES = 26
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic [6:0]  DADDR,
  input  logic        DEN,
  input  logic        DWE,
  input  logic [15:0] DI,
  input  logic [47:0] sample_data,
  output logic [15:0] DO,
  output logic        DRDY,
  output logic        BUSY,
  output logic        EOS,
  output logic        drp_err,
  output logic        alarm
);

  logic [15:0] res_q [4];
  logic [15:0] cfg0_q, cfg1_q, seq_q;
  logic        pend_q, drdy_q, err_q, we_q;
  logic [3:0]  cnt_q;
  logic [6:0]  addr_q;
  logic [15:0] wdata_q, rdata_q, do_q;
  logic [15:0] rd_val;
  logic [11:0] samp;
  logic        accept, commit;
  logic        seq_load;
  logic [1:0]  seq_ch;

`ifdef DRP_RESP_ALARM_EN
  logic [15:0] alm_thr_q;
  logic        alarm_q;
`endif

  // An access is pending from the accepting edge through its DRDY cycle.
  assign accept = DEN && !pend_q;
  assign commit = drdy_q && we_q;

  // Read value sampled in the DEN cycle, so a coincident result update
  // is seen only by later reads.
  always_comb begin
    rd_val = 16'h0000;
    if (DADDR[6:2] == C_ADDR_VAUX0[6:2]) begin
      rd_val = res_q[DADDR[1:0]];
    end else begin
      case (DADDR)
        C_ADDR_CFG0: rd_val = cfg0_q;
        C_ADDR_CFG1: rd_val = cfg1_q;
        C_ADDR_SEQ:  rd_val = seq_q;
`ifdef DRP_RESP_ALARM_EN
        C_ADDR_ALM:  rd_val = alm_thr_q;
`endif
        default:     rd_val = 16'h0000;
      endcase
    end
  end

  // Access engine: DRDY lands DRP_LATENCY cycles after the DEN cycle.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      pend_q  <= 1'b0;
      drdy_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= 4'd0;
      addr_q  <= 7'd0;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
      do_q    <= 16'h0000;
    end else begin
      if (DEN && pend_q) err_q <= 1'b1;
      if (accept) begin
        pend_q  <= 1'b1;
        addr_q  <= DADDR;
        we_q    <= DWE;
        wdata_q <= DI;
        rdata_q <= rd_val;
        if (DRP_LATENCY == 1) begin
          drdy_q <= 1'b1;
          do_q   <= DWE ? DI : rd_val;
        end else begin
          cnt_q <= 4'(DRP_LATENCY - 1);
        end
      end else if (drdy_q) begin
        drdy_q <= 1'b0;
        pend_q <= 1'b0;
      end else if (pend_q) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          drdy_q <= 1'b1;
          do_q   <= we_q ? wdata_q : rdata_q;
        end
      end
    end
  end

  // Configuration registers; result addresses and unmapped writes fall
  // through to the default and are dropped.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      cfg0_q <= C_CFG0_RST;
      cfg1_q <= C_CFG1_RST;
      seq_q  <= C_SEQ_RST;
    end else if (commit) begin
      case (addr_q)
        C_ADDR_CFG0: cfg0_q <= wdata_q;
        C_ADDR_CFG1: cfg1_q <= wdata_q;
        C_ADDR_SEQ:  seq_q  <= wdata_q;
        default:     ;
      endcase
    end
  end

  always_comb begin
    case (seq_ch)
      2'd0:    samp = sample_data[11:0];
      2'd1:    samp = sample_data[23:12];
      2'd2:    samp = sample_data[35:24];
      default: samp = sample_data[47:36];
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) res_q[i] <= 16'h0000;
    end else if (seq_load) begin
      res_q[seq_ch] <= {samp, 4'h0};
    end
  end

`ifdef DRP_RESP_ALARM_EN
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      alm_thr_q <= C_ALM_RST;
      alarm_q   <= 1'b0;
    end else begin
      if (commit && (addr_q == C_ADDR_ALM)) alm_thr_q <= wdata_q;
      if (seq_load && (seq_ch == 2'd0)) alarm_q <= ({samp, 4'h0} > alm_thr_q);
    end
  end
  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

  drp_resp_sequencer #(
    .CONV_CYCLES(CONV_CYCLES)
  ) u_seq (
    .clk_i      (S_AXI_ACLK),
    .rst_ni     (S_AXI_ARESETN),
    .cont_mode_i(cfg0_q[15:12] == C_MODE_CONT),
    .mask_i     (seq_q[3:0]),
    .busy_o     (BUSY),
    .eos_o      (EOS),
    .load_o     (seq_load),
    .load_ch_o  (seq_ch)
  );

  assign DO      = do_q;
  assign DRDY    = drdy_q;
  assign drp_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_drp_xadc_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_drp_xadc_responder
// Description : Directed self-checking bench for drp_xadc_responder. Expected
//               DRP read data is queued when a request is issued and popped
//               when DRDY arrives. Define DRP_RESP_ALARM_EN for alarm steps.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_drp_xadc_responder;

  localparam int LAT  = 4;
  localparam int CONV = 26;

  logic        clk = 1'b0;
  logic        rstn;
  logic [6:0]  DADDR;
  logic        DEN, DWE;
  logic [15:0] DI;
  logic [47:0] sample;
  logic [15:0] DO;
  logic        DRDY, BUSY, EOS, drp_err, alarm;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  drp_xadc_responder #(.DRP_LATENCY(LAT), .CONV_CYCLES(CONV)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn), .DADDR(DADDR), .DEN(DEN),
    .DWE(DWE), .DI(DI), .sample_data(sample), .DO(DO), .DRDY(DRDY),
    .BUSY(BUSY), .EOS(EOS), .drp_err(drp_err), .alarm(alarm)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One DRP access; checks latency, data, single-cycle DRDY and DO hold.
  task automatic drp(input logic [6:0] a, input logic we, input logic [15:0] d,
                     input logic [15:0] exp, input string tag);
    int lat;
    logic [15:0] e;
    exp_q.push_back(exp);
    DADDR = a; DWE = we; DI = d; DEN = 1'b1;
    step();
    DEN = 1'b0; DWE = 1'b0;
    lat = 1;
    while (!DRDY && lat < 32) begin step(); lat++; end
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    e = exp_q.pop_front();
    check({tag, "_do"}, 32'(DO), 32'(e));
    step();
    check({tag, "_pulse"}, 32'(DRDY), 32'(0));
    check({tag, "_hold"}, 32'(DO), 32'(e));
  endtask

  task automatic wait_eos(input string tag);
    int n = 0;
    while (!EOS && n < 2000) begin step(); n++; end
    check({tag, "_eos"}, 32'(EOS), 32'(1));
  endtask

  // Called in an EOS cycle; profiles the following sequence up to its EOS.
  task automatic measure_seq(input int exp_runs, input string tag);
    int runs = 0, len = 0, gap = 0, n = 0, badlen = 0, badgap = 0;
    step();
    check({tag, "_start"}, 32'(BUSY), 32'(1));
    while (!EOS && n < 2000) begin
      if (BUSY) begin
        if (gap > 1) badgap++;
        gap = 0;
        len++;
      end else begin
        if (len != 0) begin
          if (len != CONV) badlen++;
          runs++;
        end
        len = 0;
        gap++;
      end
      step();
      n++;
    end
    if (len != 0) begin
      if (len != CONV) badlen++;
      runs++;
    end
    check({tag, "_eos"}, 32'(EOS), 32'(1));
    check({tag, "_eos_after_busy"}, 32'(gap), 32'(0));
    check({tag, "_runs"}, 32'(runs), 32'(exp_runs));
    check({tag, "_badlen"}, 32'(badlen), 32'(0));
    check({tag, "_badgap"}, 32'(badgap), 32'(0));
    step();
    check({tag, "_eos_pulse"}, 32'(EOS), 32'(0));
  endtask

  initial begin
    int runs, n, busy_n, drdy_n, eos_n;
    logic prev;
    logic [15:0] e, do_seen;

    rstn = 1'b0; DEN = 1'b0; DWE = 1'b0; DADDR = 7'h00; DI = 16'h0000;
    sample = {12'h789, 12'hABC, 12'h456, 12'h100};
    repeat (3) step();
    check("rst_do",    32'(DO),      32'(0));
    check("rst_drdy",  32'(DRDY),    32'(0));
    check("rst_busy",  32'(BUSY),    32'(0));
    check("rst_eos",   32'(EOS),     32'(0));
    check("rst_err",   32'(drp_err), 32'(0));
    check("rst_alarm", 32'(alarm),   32'(0));
    rstn = 1'b1;
    step();

    // Reset read-back and unmapped reads
    drp(7'h41, 1'b0, 16'h0000, 16'h2000, "rd41");
    drp(7'h42, 1'b0, 16'h0000, 16'h0400, "rd42");
    drp(7'h49, 1'b0, 16'h0000, 16'h000F, "rd49");
    drp(7'h00, 1'b0, 16'h0000, 16'h0000, "rd00");
`ifdef DRP_RESP_ALARM_EN
    drp(7'h50, 1'b0, 16'h0000, 16'hFFFF, "rd50");
`else
    drp(7'h50, 1'b0, 16'h0000, 16'h0000, "rd50");
`endif

    // Full four-channel sequence
    wait_eos("seq1");
    measure_seq(4, "seq_full");
    drp(7'h12, 1'b0, 16'h0000, 16'hABC0, "rd12");
    drp(7'h10, 1'b0, 16'h0000, 16'h1000, "rd10");
    drp(7'h20, 1'b1, 16'h5555, 16'h5555, "wr20");
    drp(7'h20, 1'b0, 16'h0000, 16'h0000, "rd20");

    // Mask write during ch1: ch2/ch3 still run, next sequence is ch0 only
    wait_eos("mm");
    repeat (30) step();
    drp(7'h49, 1'b1, 16'h0001, 16'h0001, "wr49");
    runs = 0; n = 0; prev = BUSY;
    while (!EOS && n < 2000) begin
      if (BUSY && !prev) runs++;
      prev = BUSY;
      step();
      n++;
    end
    check("mm_rest_runs", 32'(runs), 32'(2));
    measure_seq(1, "seq_ch0");
    sample = {12'h789, 12'hABC, 12'h333, 12'h222};
    wait_eos("mm2");
    drp(7'h10, 1'b0, 16'h0000, 16'h2220, "rd10_new");

    // Write to read-only result register is dropped
    drp(7'h11, 1'b1, 16'h1234, 16'h1234, "wr11_ro");
    drp(7'h11, 1'b0, 16'h0000, 16'h4560, "rd11");

`ifdef DRP_RESP_ALARM_EN
    drp(7'h50, 1'b1, 16'h8000, 16'h8000, "wr50");
    drp(7'h50, 1'b0, 16'h0000, 16'h8000, "rd50_thr");
    sample[11:0] = 12'h900;
    wait_eos("alm_a"); step(); wait_eos("alm_b");
    check("alarm_high", 32'(alarm), 32'(1));
    sample[11:0] = 12'h100;
    wait_eos("alm_c"); step(); wait_eos("alm_d");
    check("alarm_low", 32'(alarm), 32'(0));
`else
    drp(7'h50, 1'b1, 16'h8000, 16'h8000, "wr50");
    drp(7'h50, 1'b0, 16'h0000, 16'h0000, "rd50_unmapped");
    sample[11:0] = 12'hFFF;
    wait_eos("alm_a"); step(); wait_eos("alm_b");
    check("alarm_tied", 32'(alarm), 32'(0));
`endif

    // Leaving continuous mode mid-sequence: finish it, then stay idle
    wait_eos("mode"); step();
    repeat (5) step();
    drp(7'h41, 1'b1, 16'h0000, 16'h0000, "wr41_off");
    wait_eos("mode_fin");
    busy_n = 0;
    for (int i = 0; i < 60; i++) begin step(); if (BUSY) busy_n++; end
    check("mode_idle_busy", 32'(busy_n), 32'(0));
    drp(7'h41, 1'b0, 16'h0000, 16'h0000, "rd41_off");
    drp(7'h41, 1'b1, 16'h2000, 16'h2000, "wr41_on");

    // Overlapping DEN two cycles after the first
    exp_q.push_back(16'h0400);
    DADDR = 7'h42; DEN = 1'b1; step();
    DEN = 1'b0; step();
    DADDR = 7'h49; DEN = 1'b1; step();
    DEN = 1'b0;
    drdy_n = 0; do_seen = 16'h0000;
    for (int i = 0; i < 12; i++) begin
      if (DRDY) begin drdy_n++; do_seen = DO; end
      step();
    end
    e = exp_q.pop_front();
    check("perr_drdy_n", 32'(drdy_n), 32'(1));
    check("perr_do", 32'(do_seen), 32'(e));
    check("perr_flag", 32'(drp_err), 32'(1));
    repeat (20) step();
    check("perr_sticky", 32'(drp_err), 32'(1));

    // Reset during an access and a conversion
    DADDR = 7'h42; DEN = 1'b1; step();
    DEN = 1'b0; step();
    rstn = 1'b0; step();
    check("rst2_busy", 32'(BUSY),    32'(0));
    check("rst2_eos",  32'(EOS),     32'(0));
    check("rst2_err",  32'(drp_err), 32'(0));
    drdy_n = 0; eos_n = 0; busy_n = 0;
    step();
    if (DRDY) drdy_n++;
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (DRDY) drdy_n++;
      if (EOS) eos_n++;
      if (BUSY) busy_n++;
    end
    check("rst2_no_drdy", 32'(drdy_n), 32'(0));
    check("rst2_no_eos",  32'(eos_n),  32'(0));
    check("rst2_restart", 32'(busy_n), 32'(10));
    drp(7'h12, 1'b0, 16'h0000, 16'h0000, "rd12_rst");
    drp(7'h49, 1'b0, 16'h0000, 16'h000F, "rd49_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
